// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port memory bus between instruction
// fetch and the load/store data path. Each access is one handshake
// transaction. The block does byte-lane steering for lbu/sb, rejects
// misaligned word accesses, aborts bus cycles that time out, and holds the
// pipeline while a requester waits.
module mips_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic              d_word_we,
    input  logic              d_byte_we,
    input  logic              d_byte_load,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              stall,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2,
        RESP  = 2'd3
    } state_t;

    // last_grant encoding: 0 = instruction fetch, 1 = data path
    localparam logic GRANT_IF   = 1'b0;
    localparam logic GRANT_DATA = 1'b1;
    // The counter reaching TIMEOUT-1 while still waiting means this is the
    // TIMEOUT-th cycle with mem_valid high and no mem_ready.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              mem_we_q, mem_we_d;
    logic [1:0]        lane_q, lane_d;
    logic              byte_load_q, byte_load_d;
    logic              misal_q, misal_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              bus_err_q, bus_err_d;

    // Decode of the data request; a word store overrides any byte flags.
    logic d_store_s;
    logic d_word_access_s;
    logic d_misal_s;

    // Zero-extended byte from the selected little-endian lane.
    function automatic logic [31:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
        logic [31:0] r;
        case (lane)
            2'd0:    r = {24'h000000, w[7:0]};
            2'd1:    r = {24'h000000, w[15:8]};
            2'd2:    r = {24'h000000, w[23:16]};
            2'd3:    r = {24'h000000, w[31:24]};
            default: r = 32'h00000000;
        endcase
        return r;
    endfunction

    // Classify the pending data request (store kind, word vs byte, alignment).
    always_comb begin
        d_store_s       = d_word_we | d_byte_we;
        d_word_access_s = d_word_we | (~d_byte_we & ~d_byte_load);
        d_misal_s       = d_word_access_s & (d_addr[1:0] != 2'b00);
    end

    // Next-state logic: arbitration, bus sequencing, timeout and response.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        mem_we_d     = mem_we_q;
        lane_d       = lane_q;
        byte_load_d  = byte_load_q;
        misal_d      = misal_q;
        if_ready_d   = 1'b0;
        d_ready_d    = 1'b0;
        if_rdata_d   = 32'h00000000;
        d_rdata_d    = 32'h00000000;
        bus_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req && (!if_req || (last_grant_q == GRANT_IF))) begin
                    state_d      = DATA;
                    last_grant_d = GRANT_DATA;
                    cnt_d        = 16'd0;
                    mem_addr_d   = {d_addr[ADDR_W-1:2], 2'b00};
                    lane_d       = d_addr[1:0];
                    byte_load_d  = d_byte_load & ~d_store_s;
                    misal_d      = d_misal_s;
                    mem_valid_d  = ~d_misal_s;
                    mem_we_d     = d_store_s;
                    if (d_word_we) begin
                        mem_be_d    = 4'hF;
                        mem_wdata_d = d_wdata;
                    end else if (d_byte_we) begin
                        mem_be_d    = 4'(4'b0001 << d_addr[1:0]);
                        mem_wdata_d = {4{d_wdata[7:0]}};
                    end else begin
                        mem_be_d    = 4'h0;
                        mem_wdata_d = 32'h00000000;
                    end
                end else if (if_req) begin
                    state_d      = FETCH;
                    last_grant_d = GRANT_IF;
                    cnt_d        = 16'd0;
                    mem_addr_d   = {if_addr[ADDR_W-1:2], 2'b00};
                    lane_d       = 2'b00;
                    byte_load_d  = 1'b0;
                    misal_d      = 1'b0;
                    mem_valid_d  = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_be_d     = 4'h0;
                    mem_wdata_d  = 32'h00000000;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA, FETCH: begin
                if (misal_q) begin
                    state_d   = RESP;
                    d_ready_d = 1'b1;
                    bus_err_d = 1'b1;
                end else if (mem_ready) begin
                    state_d     = RESP;
                    mem_valid_d = 1'b0;
                    if (state_q == DATA) begin
                        d_ready_d = 1'b1;
                        if (mem_we_q) begin
                            d_rdata_d = 32'h00000000;
                        end else if (byte_load_q) begin
                            d_rdata_d = lane_byte(mem_rdata, lane_q);
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d     = RESP;
                    mem_valid_d = 1'b0;
                    bus_err_d   = 1'b1;
                    if (state_q == DATA) begin
                        d_ready_d = 1'b1;
                    end else begin
                        if_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                state_d     = IDLE;
                misal_d     = 1'b0;
                mem_we_d    = 1'b0;
                mem_be_d    = 4'h0;
                mem_wdata_d = 32'h00000000;
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset aborts any transaction at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_IF;
            cnt_q        <= 16'd0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h00000000;
            mem_be_q     <= 4'h0;
            mem_we_q     <= 1'b0;
            lane_q       <= 2'b00;
            byte_load_q  <= 1'b0;
            misal_q      <= 1'b0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
            if_rdata_q   <= 32'h00000000;
            d_rdata_q    <= 32'h00000000;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            mem_we_q     <= mem_we_d;
            lane_q       <= lane_d;
            byte_load_q  <= byte_load_d;
            misal_q      <= misal_d;
            if_ready_q   <= if_ready_d;
            d_ready_q    <= d_ready_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Stall is combinational so the pipeline holds in the request cycle; it
    // is forced low during reset so every output reads 0 then.
    always_comb begin
        stall = ~reset & ((if_req & ~if_ready_q) | (d_req & ~d_ready_q));
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign mem_we    = mem_we_q;
    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed scenarios plus randomized loads,
// stores and fetches checked against a byte-addressed reference memory.
module tb_mips_mem_arbiter;
    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_word_we, d_byte_we, d_byte_load;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, stall, mem_valid, mem_we, bus_err;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int nchk = 0;
    int nfail = 0;

    // Bus-side memory (written only through the DUT's byte enables) and an
    // independent byte-level reference image of the same 256 bytes.
    logic [31:0] bus_mem [0:63];
    logic [7:0]  ref_bytes [0:255];
    bit          resp_en = 1'b1;
    int          resp_wait = 0;
    bit          force_en = 1'b0;
    logic [31:0] force_word = 32'h0;
    int          wcnt = 0;

    always #5 clock = ~clock;

    mips_mem_arbiter #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_word_we(d_word_we),
        .d_byte_we(d_byte_we), .d_byte_load(d_byte_load), .d_rdata(d_rdata), .d_ready(d_ready),
        .stall(stall), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_err(bus_err)
    );

    // Memory responder: answers a held mem_valid after resp_wait extra cycles.
    always @(negedge clock) begin
        if (mem_valid && resp_en) begin
            if (wcnt >= resp_wait) begin
                mem_ready = 1'b1;
                mem_rdata = force_en ? force_word : bus_mem[mem_addr[7:2]];
                if (mem_we) begin
                    for (int i = 0; i < 4; i++)
                        if (mem_be[i]) bus_mem[mem_addr[7:2]][8*i +: 8] = mem_wdata[8*i +: 8];
                end
                wcnt = 0;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                wcnt++;
            end
        end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            wcnt = 0;
        end
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] w);
        bus_mem[a[7:2]] = w;
        for (int i = 0; i < 4; i++) ref_bytes[{a[7:2], 2'(i)}] = w[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        return {ref_bytes[{a[7:2], 2'd3}], ref_bytes[{a[7:2], 2'd2}],
                ref_bytes[{a[7:2], 2'd1}], ref_bytes[{a[7:2], 2'd0}]};
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_word_we = 1'b0; d_byte_we = 1'b0; d_byte_load = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // op: 0=lw 1=lbu 2=sw 3=sb. Cycle 0 is the cycle d_req is raised.
    task automatic drive_data(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                              output bit got, output logic [31:0] rdata, output logic err,
                              output int lat, output logic [31:0] f_addr, output logic [3:0] f_be,
                              output logic [31:0] f_wdata, output logic f_we, output int vcyc,
                              output logic [7:0] stall_hist);
        bit seen = 1'b0;
        got = 1'b0; rdata = 32'hx; err = 1'bx; lat = -1; vcyc = 0; stall_hist = 8'h00;
        f_addr = 32'hx; f_be = 4'hx; f_wdata = 32'hx; f_we = 1'bx;
        @(negedge clock);
        d_req = 1'b1; d_addr = addr; d_wdata = wdata;
        d_word_we = (op == 2); d_byte_we = (op == 3); d_byte_load = (op == 1);
        #1 stall_hist[0] = stall;
        for (int k = 1; k < 40 && !got; k++) begin
            @(negedge clock);
            if (k < 8) stall_hist[k] = stall;
            if (mem_valid) begin
                if (!seen) begin
                    f_addr = mem_addr; f_be = mem_be; f_wdata = mem_wdata; f_we = mem_we;
                end
                seen = 1'b1;
                vcyc++;
            end
            if (d_ready) begin
                got = 1'b1; rdata = d_rdata; err = bus_err; lat = k;
            end
        end
        d_req = 1'b0; d_word_we = 1'b0; d_byte_we = 1'b0; d_byte_load = 1'b0;
    endtask

    task automatic drive_fetch(input logic [31:0] addr, output bit got, output logic [31:0] rdata,
                               output logic err, output int lat, output logic [31:0] f_addr,
                               output logic f_we, output logic [3:0] f_be);
        bit seen = 1'b0;
        got = 1'b0; rdata = 32'hx; err = 1'bx; lat = -1;
        f_addr = 32'hx; f_we = 1'bx; f_be = 4'hx;
        @(negedge clock);
        if_req = 1'b1; if_addr = addr;
        for (int k = 1; k < 40 && !got; k++) begin
            @(negedge clock);
            if (mem_valid && !seen) begin
                f_addr = mem_addr; f_we = mem_we; f_be = mem_be; seen = 1'b1;
            end
            if (if_ready) begin
                got = 1'b1; rdata = if_rdata; err = bus_err; lat = k;
            end
        end
        if_req = 1'b0;
    endtask

    bit          g;
    logic [31:0] rd, fa, fw;
    logic        er, fwe;
    logic [3:0]  fbe;
    int          lt, vc;
    logic [7:0]  sh;

    task automatic test_reset();
        reset = 1'b1;
        if_req = 1'b1; d_req = 1'b0; d_word_we = 1'b0; d_byte_we = 1'b0; d_byte_load = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        #1;
        nchk++;
        if ({mem_valid, if_ready, d_ready, stall, bus_err, mem_we, mem_be} !== 10'h000) begin
            nfail++; $display("FAIL reset_ctrl got %b exp 0", {mem_valid, if_ready, d_ready, stall, bus_err, mem_we, mem_be});
        end
        nchk++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
            nfail++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
        end
        apply_reset();
    endtask

    task automatic test_lw();
        resp_en = 1'b1; resp_wait = 1; force_en = 1'b1; force_word = 32'hDEADBEEF;
        drive_data(0, 32'h100, 32'h0, g, rd, er, lt, fa, fbe, fw, fwe, vc, sh);
        force_en = 1'b0;
        nchk++; if (g !== 1'b1) begin nfail++; $display("FAIL lw_done got %b exp 1", g); end
        nchk++; if (rd !== 32'hDEADBEEF) begin nfail++; $display("FAIL lw_rdata got %h exp deadbeef", rd); end
        nchk++; if (lt !== 3) begin nfail++; $display("FAIL lw_latency got %0d exp 3", lt); end
        nchk++; if ({fa, fbe, fwe} !== {32'h100, 4'h0, 1'b0}) begin nfail++; $display("FAIL lw_bus got %h/%h/%b exp 100/0/0", fa, fbe, fwe); end
        nchk++; if (sh[3:0] !== 4'b0111) begin nfail++; $display("FAIL lw_stall got %b exp 0111", sh[3:0]); end
        nchk++; if (er !== 1'b0) begin nfail++; $display("FAIL lw_err got %b exp 0", er); end
    endtask

    task automatic test_sb_lbu();
        resp_en = 1'b1; resp_wait = 0;
        drive_data(3, 32'h203, 32'h000000A5, g, rd, er, lt, fa, fbe, fw, fwe, vc, sh);
        nchk++; if ({fa, fbe, fw, fwe} !== {32'h200, 4'b1000, 32'hA5A5A5A5, 1'b1}) begin
            nfail++; $display("FAIL sb_bus got %h/%b/%h/%b exp 200/1000/a5a5a5a5/1", fa, fbe, fw, fwe); end
        nchk++; if ({g, rd, er} !== {1'b1, 32'h0, 1'b0}) begin nfail++; $display("FAIL sb_resp got %b/%h/%b exp 1/0/0", g, rd, er); end
        force_en = 1'b1; force_word = 32'hA5000000;
        drive_data(1, 32'h203, 32'h0, g, rd, er, lt, fa, fbe, fw, fwe, vc, sh);
        force_en = 1'b0;
        nchk++; if ({g, rd} !== {1'b1, 32'h000000A5}) begin nfail++; $display("FAIL lbu_rdata got %b/%h exp 1/a5", g, rd); end
        nchk++; if ({fa, fbe, fwe} !== {32'h200, 4'h0, 1'b0}) begin nfail++; $display("FAIL lbu_bus got %h/%h/%b exp 200/0/0", fa, fbe, fwe); end
    endtask

    task automatic test_misaligned();
        resp_en = 1'b1; resp_wait = 0;
        drive_data(2, 32'h102, 32'h12345678, g, rd, er, lt, fa, fbe, fw, fwe, vc, sh);
        nchk++; if (vc !== 0) begin nfail++; $display("FAIL sw_mis_valid got %0d exp 0", vc); end
        nchk++; if ({g, er, rd} !== {1'b1, 1'b1, 32'h0}) begin nfail++; $display("FAIL sw_mis_resp got %b/%b/%h exp 1/1/0", g, er, rd); end
        nchk++; if (lt !== 2) begin nfail++; $display("FAIL sw_mis_latency got %0d exp 2", lt); end
        drive_data(0, 32'h41, 32'h0, g, rd, er, lt, fa, fbe, fw, fwe, vc, sh);
        nchk++; if ({g, er, rd, vc} !== {1'b1, 1'b1, 32'h0, 32'd0}) begin nfail++; $display("FAIL lw_mis got %b/%b/%h/%0d exp 1/1/0/0", g, er, rd, vc); end
    endtask

    task automatic test_timeout();
        resp_en = 1'b0;
        drive_data(0, 32'h40, 32'h0, g, rd, er, lt, fa, fbe, fw, fwe, vc, sh);
        nchk++; if (vc !== TMO) begin nfail++; $display("FAIL tmo_valid_cycles got %0d exp %0d", vc, TMO); end
        nchk++; if ({g, er, rd} !== {1'b1, 1'b1, 32'h0}) begin nfail++; $display("FAIL tmo_resp got %b/%b/%h exp 1/1/0", g, er, rd); end
        nchk++; if (lt !== TMO + 1) begin nfail++; $display("FAIL tmo_latency got %0d exp %0d", lt, TMO + 1); end
        resp_en = 1'b1; resp_wait = 0;
        preload(8'h44, 32'hCAFEF00D);
        drive_fetch(32'h46, g, rd, er, lt, fa, fwe, fbe);
        nchk++; if ({g, rd, er} !== {1'b1, 32'hCAFEF00D, 1'b0}) begin nfail++; $display("FAIL tmo_then_fetch got %b/%h/%b exp 1/cafef00d/0", g, rd, er); end
        nchk++; if ({fa, fwe, fbe} !== {32'h44, 1'b0, 4'h0}) begin nfail++; $display("FAIL fetch_bus got %h/%b/%h exp 44/0/0", fa, fwe, fbe); end
    endtask

    task automatic test_arbitration();
        int n = 0;
        logic [3:0] order = 4'h0;
        apply_reset();
        resp_en = 1'b1; resp_wait = 0;
        preload(8'h10, 32'h11112222);
        preload(8'h20, 32'h33334444);
        @(negedge clock);
        if_req = 1'b1; if_addr = 32'h13; d_req = 1'b1; d_addr = 32'h20;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clock);
            if (d_ready) begin
                order[n] = 1'b1; n++;
                nchk++; if (d_rdata !== 32'h33334444) begin nfail++; $display("FAIL arb_d_rdata got %h exp 33334444", d_rdata); end
            end
            if (if_ready) begin
                order[n] = 1'b0; n++;
                nchk++; if (if_rdata !== 32'h11112222) begin nfail++; $display("FAIL arb_if_rdata got %h exp 11112222", if_rdata); end
            end
            if (n >= 4) begin if_req = 1'b0; d_req = 1'b0; end
        end
        if_req = 1'b0; d_req = 1'b0;
        nchk++; if (n !== 4) begin nfail++; $display("FAIL arb_count got %0d exp 4", n); end
        nchk++; if (order !== 4'b0101) begin nfail++; $display("FAIL arb_order got %b exp 0101 (bit0 first, 1=data)", order); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        bit first_d = 1'b0;
        bit done = 1'b0;
        resp_en = 1'b0;
        @(negedge clock);
        if_req = 1'b1; if_addr = 32'h30;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clock);
            if (mem_valid) seen = 1'b1;
        end
        nchk++; if (seen !== 1'b1) begin nfail++; $display("FAIL rstmid_fetch_started got %b exp 1", seen); end
        #2 reset = 1'b1;
        #1;
        nchk++; if ({mem_valid, stall, if_ready} !== 3'b000) begin nfail++; $display("FAIL rstmid_drop got %b exp 000", {mem_valid, stall, if_ready}); end
        d_req = 1'b1; d_addr = 32'h20;
        @(negedge clock);
        reset = 1'b0; resp_en = 1'b1; resp_wait = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clock);
            if (d_ready || if_ready) begin
                done = 1'b1; first_d = d_ready;
                if_req = 1'b0; d_req = 1'b0;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        nchk++; if ({done, first_d} !== 2'b11) begin nfail++; $display("FAIL rstmid_first_grant got %b exp 11", {done, first_d}); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++) preload(8'(i * 4), $urandom);
        resp_en = 1'b1;
        for (int t = 0; t < 60; t++) begin
            int op = $urandom_range(0, 4);
            logic [7:0] a = 8'($urandom_range(0, 255));
            logic [31:0] exp_rd;
            logic exp_err;
            int exp_lat;
            if ((op == 0 || op == 2) && ($urandom_range(0, 4) != 0)) a[1:0] = 2'b00;
            resp_wait = $urandom_range(0, TMO - 1);
            exp_err = 1'b0; exp_lat = resp_wait + 2; exp_rd = 32'h0;
            if (op == 4) begin
                exp_rd = ref_word(a);
                drive_fetch({24'h0, a}, g, rd, er, lt, fa, fwe, fbe);
            end else begin
                logic [31:0] wd = $urandom;
                if ((op == 0 || op == 2) && a[1:0] != 2'b00) begin
                    exp_err = 1'b1; exp_lat = 2;
                end else if (op == 0) exp_rd = ref_word(a);
                else if (op == 1) exp_rd = {24'h0, ref_bytes[a]};
                else if (op == 2) for (int i = 0; i < 4; i++) ref_bytes[{a[7:2], 2'(i)}] = wd[8*i +: 8];
                else ref_bytes[a] = wd[7:0];
                drive_data(op, {24'h0, a}, wd, g, rd, er, lt, fa, fbe, fw, fwe, vc, sh);
            end
            nchk++;
            if ({g, rd, er} !== {1'b1, exp_rd, exp_err}) begin
                nfail++; $display("FAIL rand_resp op%0d addr %h got %b/%h/%b exp 1/%h/%b", op, a, g, rd, er, exp_rd, exp_err);
            end
            nchk++;
            if (lt !== exp_lat) begin nfail++; $display("FAIL rand_latency op%0d wait %0d got %0d exp %0d", op, resp_wait, lt, exp_lat); end
        end
        for (int i = 0; i < 64; i++) begin
            nchk++;
            if (bus_mem[i] !== ref_word(8'(i * 4))) begin
                nfail++; $display("FAIL rand_mem word %0d got %h exp %h", i, bus_mem[i], ref_word(8'(i * 4)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sb_lbu();
        test_misaligned();
        test_timeout();
        test_arbitration();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench time limit");
    end

endmodule
